// File: rtl/huffman_bit_packer.sv
// Purpose: packs a serial MSB-first Huffman code stream into WIDTH-bit words behind a small FIFO.
// Latency: a word reaches the FIFO head (m_valid=1) on the cycle after the edge that sampled its final bit.
// Backpressure: m_ready=0 holds the head stable; a push into a full FIFO with no pop is dropped and flags overflow.

// Generic registered FIFO with no combinational bypass; reports pushes it had to drop.
module huffman_bit_packer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_rdy_i,
  output logic         head_vld_o,
  output logic [W-1:0] head_dat_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [AW:0]  fill;
  logic         empty;
  logic         full;
  logic         pop;
  logic         wr_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fill  = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (fill == DEPTH_P);
  assign pop   = !empty && pop_rdy_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en  = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;

  assign head_vld_o = !empty;
  assign head_dat_o = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // Storage and pointer update; reset discards every queued word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_q[AW-1:0]] <= push_dat_i;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

endmodule

// Bit packer top: stream FSM, shift register, counters and output FIFO.
module huffman_bit_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_start,
  input  logic                       bit_done,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(WIDTH+1)-1:0] m_nbits,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CNT_W-1:0]           total_bits,
  output logic                       overflow,
  output logic                       proto_err
);

  localparam int NB_W  = $clog2(WIDTH+1);
  localparam int ENT_W = 1 + NB_W + WIDTH;
  localparam logic [NB_W-1:0] WIDTH_NB = NB_W'(WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PACK = 1'b1;

  logic [0:0]       state_q,   state_d;
  // Only WIDTH-1 earlier bits are kept: the current bit completes the word combinationally.
  logic [WIDTH-2:0] shreg_q,   shreg_d;
  logic [NB_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] run_q,     run_d;
  logic [CNT_W-1:0] total_q,   total_d;
  logic             ovf_q,     ovf_d;
  logic             perr_q,    perr_d;

  logic             sample;
  logic [WIDTH-1:0] word_new;
  logic [WIDTH-1:0] word_pad;
  logic [NB_W-1:0]  cnt_new;
  logic [CNT_W-1:0] run_new;
  logic             word_full;
  logic             push;
  logic [ENT_W-1:0] push_dat;
  logic [ENT_W-1:0] head_dat;
  logic             fifo_drop;

  // A bit is taken in PACK, or in IDLE only when it opens a stream.
  assign sample = bit_start | (state_q == ST_PACK);

  // bit_start always restarts the word and stream count from the current bit,
  // which also covers discarding a partial word on a protocol error.
  assign word_new = bit_start ? {{(WIDTH-1){1'b0}}, bit_in} : {shreg_q, bit_in};
  assign cnt_new  = (bit_start ? '0 : bit_cnt_q) + NB_W'(1);
  assign run_new  = (bit_start ? '0 : run_q) + CNT_W'(1);

  assign word_full = (cnt_new == WIDTH_NB);
  // Partial final word: left-align the valid bits; older garbage shifts out the top.
  assign word_pad  = word_full ? word_new : (word_new << (WIDTH_NB - cnt_new));

  // A completed word and a stream end never push twice: one entry carries both.
  assign push     = sample & (word_full | bit_done);
  assign push_dat = {bit_done, cnt_new, word_pad};

  // Stream FSM, shift register and counters next-state.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    run_d     = run_q;
    total_d   = total_q;
    perr_d    = perr_q;
    if (sample) begin
      state_d   = ST_PACK;
      shreg_d   = word_new[WIDTH-2:0];
      bit_cnt_d = word_full ? '0 : cnt_new;
      run_d     = run_new;
      if (bit_start) begin
        // A clean start clears the error; a start inside a stream raises it.
        perr_d = (state_q == ST_PACK);
      end
      if (bit_done) begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        total_d   = run_new;
      end
    end
  end

  // Overflow is cleared only by a clean start; a drop in that same cycle still wins.
  always_comb begin
    ovf_d = ovf_q;
    if (bit_start && (state_q == ST_IDLE)) begin
      ovf_d = 1'b0;
    end
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      run_q     <= '0;
      total_q   <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      run_q     <= run_d;
      total_q   <= total_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
    end
  end

  huffman_bit_packer_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_rdy_i  (m_ready),
    .head_vld_o (m_valid),
    .head_dat_o (head_dat),
    .drop_o     (fifo_drop)
  );

  assign {m_last, m_nbits, m_data} = head_dat;
  assign total_bits = total_q;
  assign overflow   = ovf_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: directed scenarios plus random streams against a queue-based model.
// The model turns each stream into a bit list, cuts it into words, and tracks a bounded word queue.
// Expected values come from the model or from constants worked out by hand.
module tb_huffman_bit_packer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             bit_in;
  logic             bit_start;
  logic             bit_done;
  logic [WIDTH-1:0] m_data;
  logic [3:0]       m_nbits;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] total_bits;
  logic             overflow;
  logic             proto_err;

  huffman_bit_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_start  (bit_start),
    .bit_done   (bit_done),
    .m_data     (m_data),
    .m_nbits    (m_nbits),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .total_bits (total_bits),
    .overflow   (overflow),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: word entries are {last, nbits[3:0], data[7:0]}.
  logic [12:0] fq[$];
  logic [12:0] got[$];
  bit          wb[$];
  bit          active;
  int          run;
  logic [15:0] m_total;
  bit          m_ovf;
  bit          m_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    wb.delete();
    active  = 1'b0;
    run     = 0;
    m_total = '0;
    m_ovf   = 1'b0;
    m_perr  = 1'b0;
  endtask

  // One clock edge of the model, from the inputs presented before it.
  task automatic model_edge(input bit s, input bit d, input bit b, input bit r);
    bit          pop;
    bit          have;
    logic [12:0] w;
    pop  = (fq.size() > 0) && r;
    have = 1'b0;
    w    = '0;
    if (s || active) begin
      if (s) begin
        if (active) m_perr = 1'b1;
        else begin
          m_perr = 1'b0;
          m_ovf  = 1'b0;
        end
        wb.delete();
        run = 0;
      end
      wb.push_back(b);
      run++;
      if (wb.size() == WIDTH || d) begin
        w[12]   = d;
        w[11:8] = 4'(wb.size());
        for (int i = 0; i < wb.size(); i++) w[WIDTH-1-i] = wb[i];
        have = 1'b1;
        wb.delete();
      end
      if (d) begin
        m_total = 16'(run);
        active  = 1'b0;
      end else begin
        active = 1'b1;
      end
    end
    if (pop) void'(fq.pop_front());
    if (have) begin
      if (fq.size() < DEPTH) fq.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("m_valid", 32'(m_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("m_data",  32'(m_data),  32'(fq[0][7:0]));
      chk("m_nbits", 32'(m_nbits), 32'(fq[0][11:8]));
      chk("m_last",  32'(m_last),  32'(fq[0][12]));
    end
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("proto_err",  32'(proto_err),  32'(m_perr));
    chk("total_bits", 32'(total_bits), 32'(m_total));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(m_valid),    32'(0));
    chk({tag, "_data"},  32'(m_data),     32'(0));
    chk({tag, "_nbits"}, 32'(m_nbits),    32'(0));
    chk({tag, "_last"},  32'(m_last),     32'(0));
    chk({tag, "_total"}, 32'(total_bits), 32'(0));
    chk({tag, "_ovf"},   32'(overflow),   32'(0));
    chk({tag, "_perr"},  32'(proto_err),  32'(0));
  endtask

  // Check the settled outputs, present new inputs, and advance the model one edge.
  task automatic step(input bit s, input bit d, input bit b, input bit r);
    @(negedge clk);
    check_outputs();
    bit_start = s;
    bit_done  = d;
    bit_in    = b;
    m_ready   = r;
    if (m_valid && r) got.push_back({m_last, m_nbits, m_data});
    model_edge(s, d, b, r);
  endtask

  function automatic bit pick_ready(input int rmode);
    if (rmode == 2) return ($urandom_range(0, 3) != 0);
    return rmode[0];
  endfunction

  // Send n bits of val MSB first; rmode 0/1 fixes m_ready, 2 randomises it.
  task automatic send(input logic [63:0] val, input int n, input int rmode, input bit with_done);
    for (int i = 0; i < n; i++) begin
      step(i == 0, with_done && (i == n - 1), val[n-1-i], pick_ready(rmode));
    end
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), pick_ready(rmode));
  endtask

  initial begin
    logic [63:0] rv;
    bit_in    = 1'b0;
    bit_start = 1'b0;
    bit_done  = 1'b0;
    m_ready   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Ten-bit stream: one full word and a two-bit tail.
    got.delete();
    send(64'b1011001101, 10, 1, 1'b1);
    idle(4, 1);
    chk("t1_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t1_w0", 32'(got[0]), 32'h08B3);
      chk("t1_w1", 32'(got[1]), 32'h1240);
    end
    chk("t1_total", 32'(total_bits), 32'd10);

    // Exactly two words: no empty trailing word.
    got.delete();
    send(64'hA53C, 16, 1, 1'b1);
    idle(4, 1);
    chk("t2_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t2_w0", 32'(got[0]), 32'h08A5);
      chk("t2_w1", 32'(got[1]), 32'h183C);
    end
    chk("t2_total", 32'(total_bits), 32'd16);

    // Single-bit stream; a stray bit_done afterwards must be ignored in IDLE.
    got.delete();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(2, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(3, 1);
    chk("t3_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("t3_w0", 32'(got[0]), 32'h1180);
    chk("t3_total", 32'(total_bits), 32'd1);

    // Backpressure: five words into a four-deep FIFO.
    got.delete();
    rv = {$urandom, $urandom};
    send(rv, 40, 0, 1'b1);
    idle(3, 0);
    chk("t4_ovf", 32'(overflow), 32'd1);
    idle(10, 1);
    chk("t4_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) chk("t4_w3_last", 32'(got[3][12]), 32'd0);

    // Protocol error: restart on the fifth bit; the restarted stream is 8'hC5.
    got.delete();
    send(64'hA, 4, 1, 1'b0);
    send(64'hC5, 8, 1, 1'b1);
    idle(3, 1);
    chk("t5_perr", 32'(proto_err), 32'd1);
    chk("t5_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("t5_w0", 32'(got[0]), 32'h18C5);
    send(64'h5, 3, 1, 1'b1);
    idle(3, 1);
    chk("t5_perr_clr", 32'(proto_err), 32'd0);

    // Asynchronous reset mid-stream with one word queued.
    send(64'h7E5, 11, 0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("arst");
    bit_start = 1'b0;
    bit_done  = 1'b0;
    m_ready   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    send(64'h5A, 8, 1, 1'b1);
    idle(3, 1);
    chk("t6_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("t6_w0", 32'(got[0]), 32'h185A);

    // Random streams with random backpressure and gaps.
    for (int k = 0; k < 40; k++) begin
      rv = {$urandom, $urandom};
      send(rv, $urandom_range(1, 30), 2, 1'b1);
      idle($urandom_range(0, 3), 2);
    end
    idle(20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
